// File: rtl/tu_chain_collector.sv
// tu_chain_collector: drives the head of the test-unit pass chain, watches every unit's
// to_down_pass tap, and latches a verdict once the chain has fully passed, passed out of
// order, dropped a unit, or run out of its cycle budget.
//
// Build option: define TU_CHAIN_DROP_CHECK_EN to flag a tap that falls after being seen
// (fail_code 3). Without it the seen mask is sticky and drops are ignored.
//
// Ports:
//   clock           sole clock
//   rst             synchronous active-high reset
//   start           level; arms a run from IDLE or REPORT, ignored during RUN
//   unit_pass_taps  to_down_pass of unit i on bit i
//   chain_head_pass drives from_up_pass of unit 0 (equals busy)
//   busy            high while running
//   done            one-cycle pulse when the verdict is latched
//   pass            1 = every unit passed
//   fail_code       0 none, 1 timeout, 2 order, 3 drop
//   fail_unit       offending unit index
//   units_passed    number of units counted as passed at the verdict
//   elapsed         RUN cycles up to and including the deciding cycle
module tu_chain_collector #(
  parameter int unsigned NUM_UNITS      = 4,
  parameter int unsigned TIMEOUT_CYCLES = 100000,
  parameter int unsigned CNT_W          = 32,
  parameter int unsigned UNIT_W         = $clog2(NUM_UNITS + 1)
) (
  input  logic                 clock,
  input  logic                 rst,
  input  logic                 start,
  input  logic [NUM_UNITS-1:0] unit_pass_taps,
  output logic                 chain_head_pass,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [2:0]           fail_code,
  output logic [UNIT_W-1:0]    fail_unit,
  output logic [UNIT_W-1:0]    units_passed,
  output logic [CNT_W-1:0]     elapsed
);

  localparam logic [2:0] CodeNone    = 3'd0;
  localparam logic [2:0] CodeTimeout = 3'd1;
  localparam logic [2:0] CodeOrder   = 3'd2;
  localparam logic [2:0] CodeDrop    = 3'd3;

  typedef enum logic [1:0] {StIdle, StRun, StReport} state_e;

  state_e               state_q;
  logic [NUM_UNITS-1:0] seen_q;

  logic [NUM_UNITS-1:0] merged;
  logic [NUM_UNITS-1:0] drop_mask;
  logic [UNIT_W-1:0]    drop_unit;
  logic                 drop_found;
  logic                 order_err;
  logic [UNIT_W-1:0]    gap_unit;
  logic                 gap_found;
  logic [UNIT_W-1:0]    merged_cnt;
  logic [UNIT_W-1:0]    kept_cnt;
  logic                 all_pass;
  logic [CNT_W-1:0]     elapsed_inc;
  logic                 timeout_hit;
  logic                 verdict;
  logic                 v_pass;
  logic [2:0]           v_code;
  logic [UNIT_W-1:0]    v_unit;

  always_comb begin
    merged = seen_q | unit_pass_taps;
`ifdef TU_CHAIN_DROP_CHECK_EN
    drop_mask = seen_q & ~unit_pass_taps;
`else
    drop_mask = '0;
`endif

    drop_unit  = '0;
    drop_found = 1'b0;
    for (int unsigned i = 0; i < NUM_UNITS; i++) begin
      if (drop_mask[i] && !drop_found) begin
        drop_unit  = UNIT_W'(i);
        drop_found = 1'b1;
      end
    end

    // Not a thermometer code iff some set bit sits directly above a clear bit.
    order_err = 1'b0;
    for (int unsigned i = 1; i < NUM_UNITS; i++) begin
      if (merged[i] && !merged[i-1]) order_err = 1'b1;
    end

    // The unit blamed for an order error is the first hole: the lowest unit that has not
    // passed although a later unit already has.
    gap_unit  = '0;
    gap_found = 1'b0;
    for (int unsigned i = 0; i < NUM_UNITS; i++) begin
      if (!merged[i] && !gap_found) begin
        gap_unit  = UNIT_W'(i);
        gap_found = 1'b1;
      end
    end

    merged_cnt = '0;
    kept_cnt   = '0;
    for (int unsigned i = 0; i < NUM_UNITS; i++) begin
      merged_cnt = merged_cnt + UNIT_W'(merged[i]);
      kept_cnt   = kept_cnt + UNIT_W'(merged[i] & ~drop_mask[i]);
    end

    all_pass    = &merged;
    elapsed_inc = elapsed + CNT_W'(1);
    timeout_hit = (elapsed_inc == CNT_W'(TIMEOUT_CYCLES));

    verdict = 1'b1;
    v_pass  = 1'b0;
    v_code  = CodeNone;
    v_unit  = '0;
    if (drop_found) begin
      v_code = CodeDrop;
      v_unit = drop_unit;
    end else if (order_err) begin
      v_code = CodeOrder;
      v_unit = gap_found ? gap_unit : '0;
    end else if (all_pass) begin
      v_pass = 1'b1;
    end else if (timeout_hit) begin
      v_code = CodeTimeout;
      v_unit = merged_cnt;
    end else begin
      verdict = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      state_q         <= StIdle;
      seen_q          <= '0;
      chain_head_pass <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
      pass            <= 1'b0;
      fail_code       <= CodeNone;
      fail_unit       <= '0;
      units_passed    <= '0;
      elapsed         <= '0;
    end else begin
      done <= 1'b0;
      case (state_q)
        StIdle, StReport: begin
          if (start) begin
            state_q         <= StRun;
            chain_head_pass <= 1'b1;
            busy            <= 1'b1;
            seen_q          <= '0;
            elapsed         <= '0;
            pass            <= 1'b0;
            fail_code       <= CodeNone;
            fail_unit       <= '0;
            units_passed    <= '0;
          end
        end
        StRun: begin
          elapsed <= elapsed_inc;
          if (verdict) begin
            state_q         <= StReport;
            chain_head_pass <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b1;
            pass            <= v_pass;
            fail_code       <= v_code;
            fail_unit       <= v_unit;
            units_passed    <= kept_cnt;
          end else begin
            seen_q <= merged;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_tu_chain_collector.sv
module tb_tu_chain_collector;

  localparam int unsigned N  = 4;
  localparam int unsigned TO = 10;
  localparam int unsigned CW = 32;
  localparam int unsigned UW = $clog2(N + 1);

  logic          clock;
  logic          rst;
  logic          start;
  logic [N-1:0]  unit_pass_taps;
  logic          chain_head_pass;
  logic          busy;
  logic          done;
  logic          pass;
  logic [2:0]    fail_code;
  logic [UW-1:0] fail_unit;
  logic [UW-1:0] units_passed;
  logic [CW-1:0] elapsed;

  tu_chain_collector #(
    .NUM_UNITS      (N),
    .TIMEOUT_CYCLES (TO),
    .CNT_W          (CW)
  ) dut (
    .clock           (clock),
    .rst             (rst),
    .start           (start),
    .unit_pass_taps  (unit_pass_taps),
    .chain_head_pass (chain_head_pass),
    .busy            (busy),
    .done            (done),
    .pass            (pass),
    .fail_code       (fail_code),
    .fail_unit       (fail_unit),
    .units_passed    (units_passed),
    .elapsed         (elapsed)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic          p;
    logic [2:0]    code;
    logic [UW-1:0] unit;
    logic [UW-1:0] up;
    logic [CW-1:0] el;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   vectors;
  int   miscompares;

  function automatic exp_t mk(logic p, logic [2:0] code, int unsigned unit, int unsigned up,
                              int unsigned el);
    exp_t e;
    e.p    = p;
    e.code = code;
    e.unit = UW'(unit);
    e.up   = UW'(up);
    e.el   = CW'(el);
    return e;
  endfunction

  // Scoreboard: every done pulse must match the oldest expected verdict.
  always @(negedge clock) begin
    if (done === 1'b1) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_done: got pass=%0b code=%0d unit=%0d up=%0d el=%0d, want no done",
                 pass, fail_code, fail_unit, units_passed, elapsed);
      end else begin
        mon_e = exp_q.pop_front();
        if ({pass, fail_code, fail_unit, units_passed, elapsed} !==
            {mon_e.p, mon_e.code, mon_e.unit, mon_e.up, mon_e.el}) begin
          miscompares++;
          $display("FAIL verdict: got pass=%0b code=%0d unit=%0d up=%0d el=%0d, want pass=%0b code=%0d unit=%0d up=%0d el=%0d",
                   pass, fail_code, fail_unit, units_passed, elapsed,
                   mon_e.p, mon_e.code, mon_e.unit, mon_e.up, mon_e.el);
        end
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (done !== 1'b1 && n < budget) begin
      step();
      n++;
    end
    vectors++;
    if (done !== 1'b1) begin
      miscompares++;
      $display("FAIL wait_done: got done=%0b after %0d cycles, want done=1", done, n);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    vectors++;
    if ({busy, chain_head_pass, done, pass, fail_code, fail_unit, units_passed, elapsed} !== '0) begin
      miscompares++;
      $display("FAIL reset_state: got busy=%0b head=%0b done=%0b pass=%0b code=%0d el=%0d, want all 0",
               busy, chain_head_pass, done, pass, fail_code, elapsed);
    end
    step();
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_hold: got busy=%0b, want 0", busy);
    end
  endtask

  task automatic test_pass_seq();
    start = 1'b1;
    step();
    start = 1'b0;
    vectors++;
    if ({busy, chain_head_pass} !== 2'b11) begin
      miscompares++;
      $display("FAIL run_entry: got busy=%0b head=%0b, want 1 1", busy, chain_head_pass);
    end
    exp_q.push_back(mk(1'b1, 3'd0, 0, 4, 7));
    for (int c = 1; c <= 7; c++) begin
      unit_pass_taps = N'((1 << ((c + 1) / 2)) - 1);
      step();
      if (c < 7) begin
        vectors++;
        if (done !== 1'b0) begin
          miscompares++;
          $display("FAIL early_done: got done=%0b at cycle %0d, want 0", done, c);
        end
      end
    end
    vectors++;
    if ({done, busy} !== 2'b10) begin
      miscompares++;
      $display("FAIL seq_done: got done=%0b busy=%0b, want 1 0", done, busy);
    end
    step();
    vectors++;
    if ({done, pass} !== 2'b01) begin
      miscompares++;
      $display("FAIL report_hold: got done=%0b pass=%0b, want 0 1", done, pass);
    end
    unit_pass_taps = '0;
  endtask

  task automatic test_all_at_once();
    start = 1'b1;
    step();
    start = 1'b0;
    exp_q.push_back(mk(1'b1, 3'd0, 0, 4, 1));
    unit_pass_taps = '1;
    step();
    vectors++;
    if (done !== 1'b1) begin
      miscompares++;
      $display("FAIL all_at_once: got done=%0b, want 1", done);
    end
    unit_pass_taps = '0;
    step();
  endtask

  task automatic test_order();
    start = 1'b1;
    step();
    start = 1'b0;
    exp_q.push_back(mk(1'b0, 3'd2, 1, 2, 2));
    unit_pass_taps = 4'b0001;
    step();
    unit_pass_taps = 4'b0101;
    step();
    vectors++;
    if ({done, pass} !== 2'b10) begin
      miscompares++;
      $display("FAIL order: got done=%0b pass=%0b, want 1 0", done, pass);
    end
    unit_pass_taps = '0;
    step();
  endtask

  task automatic test_drop();
    start = 1'b1;
    step();
    start = 1'b0;
`ifdef TU_CHAIN_DROP_CHECK_EN
    exp_q.push_back(mk(1'b0, 3'd3, 0, 1, 3));
`else
    exp_q.push_back(mk(1'b1, 3'd0, 0, 4, 4));
`endif
    unit_pass_taps = 4'b0001;
    step();
    unit_pass_taps = 4'b0011;
    step();
    unit_pass_taps = 4'b0010;
    step();
`ifdef TU_CHAIN_DROP_CHECK_EN
    vectors++;
    if (done !== 1'b1) begin
      miscompares++;
      $display("FAIL drop_detect: got done=%0b, want 1", done);
    end
`else
    vectors++;
    if (done !== 1'b0) begin
      miscompares++;
      $display("FAIL drop_ignored: got done=%0b, want 0", done);
    end
    unit_pass_taps = 4'b1110;
    step();
    vectors++;
    if (done !== 1'b1) begin
      miscompares++;
      $display("FAIL drop_complete: got done=%0b, want 1", done);
    end
`endif
    unit_pass_taps = '0;
    step();
  endtask

  task automatic test_timeout();
    start = 1'b1;
    step();
    start = 1'b0;
    exp_q.push_back(mk(1'b0, 3'd1, 1, 1, TO));
    unit_pass_taps = 4'b0001;
    wait_done(TO + 5);
    unit_pass_taps = '0;
    step();
  endtask

  task automatic test_rst_mid_run();
    start = 1'b1;
    step();
    start = 1'b0;
    unit_pass_taps = 4'b0001;
    step();
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    vectors++;
    if ({busy, chain_head_pass, done, pass, fail_code, fail_unit, units_passed, elapsed} !== '0) begin
      miscompares++;
      $display("FAIL rst_mid_run: got busy=%0b head=%0b done=%0b pass=%0b code=%0d el=%0d, want all 0",
               busy, chain_head_pass, done, pass, fail_code, elapsed);
    end
    unit_pass_taps = '0;
    step();
    step();
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_stays_idle: got busy=%0b, want 0", busy);
    end
  endtask

  task automatic test_back_to_back();
    start = 1'b1;
    step();
    unit_pass_taps = '0;
    step();
    step();
    step();
    vectors++;
    if ({busy, elapsed} !== {1'b1, CW'(3)}) begin
      miscompares++;
      $display("FAIL start_ignored: got busy=%0b el=%0d, want 1 3", busy, elapsed);
    end
    exp_q.push_back(mk(1'b1, 3'd0, 0, 4, 4));
    unit_pass_taps = '1;
    step();
    vectors++;
    if (done !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_first_done: got done=%0b, want 1", done);
    end
    step();
    vectors++;
    if ({busy, done} !== 2'b10) begin
      miscompares++;
      $display("FAIL b2b_reenter: got busy=%0b done=%0b, want 1 0", busy, done);
    end
    start = 1'b0;
    exp_q.push_back(mk(1'b1, 3'd0, 0, 4, 1));
    step();
    vectors++;
    if (done !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_second_done: got done=%0b, want 1", done);
    end
    unit_pass_taps = '0;
    step();
  endtask

  initial begin
    vectors        = 0;
    miscompares    = 0;
    rst            = 1'b1;
    start          = 1'b0;
    unit_pass_taps = '0;
    test_reset();
    test_pass_seq();
    test_all_at_once();
    test_order();
    test_drop();
    test_timeout();
    test_rst_mid_run();
    test_back_to_back();
    step();
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL pending_verdicts: got %0d outstanding, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

endmodule
